// File: rtl/prog_sequencer_if.sv
// Host/fetch-stage handshake bundle for prog_sequencer.
// The sequencer takes the slave side; the harness or bench takes the master side.
interface prog_sequencer_if;
  logic        Start;
  logic [1:0]  ProgSel;
  logic        Halt;
  logic        Init;
  logic        LoadPC;
  logic [9:0]  StartAddr;
  logic [1:0]  ProgState;
  logic        Busy;
  logic        Done;
  logic        TimedOut;
  logic        BadSel;
  logic [15:0] CycleCount;

  modport master (
    output Start, ProgSel, Halt,
    input  Init, LoadPC, StartAddr, ProgState, Busy, Done, TimedOut, BadSel, CycleCount
  );

  modport slave (
    input  Start, ProgSel, Halt,
    output Init, LoadPC, StartAddr, ProgState, Busy, Done, TimedOut, BadSel, CycleCount
  );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller for the fetch stage: init hold, start-PC load, run with
// watchdog, and a four-phase Start/Done handshake. All outputs are registered.
module prog_sequencer #(
  parameter int unsigned NUM_PROGS   = 3,
  parameter logic [9:0]  START0      = 10'd0,
  parameter logic [9:0]  START1      = 10'd128,
  parameter logic [9:0]  START2      = 10'd256,
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd4000
) (
  input logic             CLK,
  input logic             Reset,
  prog_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES);

  state_t      state;
  logic [3:0]  init_cnt;
  logic [15:0] count_inc;
  logic [9:0]  sel_addr;
  logic        sel_ok;

  always_comb begin
    count_inc = (bus.CycleCount == 16'hFFFF) ? 16'hFFFF : bus.CycleCount + 16'd1;
    sel_ok    = ({30'd0, bus.ProgSel} < NUM_PROGS);
    case (bus.ProgSel)
      2'd0:    sel_addr = START0;
      2'd1:    sel_addr = START1;
      2'd2:    sel_addr = START2;
      default: sel_addr = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      init_cnt       <= '0;
      bus.Init       <= 1'b1;
      bus.LoadPC     <= 1'b0;
      bus.StartAddr  <= '0;
      bus.ProgState  <= '0;
      bus.Busy       <= 1'b0;
      bus.Done       <= 1'b0;
      bus.TimedOut   <= 1'b0;
      bus.BadSel     <= 1'b0;
      bus.CycleCount <= '0;
    end else begin
      bus.BadSel <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (sel_ok) begin
              state          <= INIT;
              init_cnt       <= INIT_LOAD;
              bus.ProgState  <= bus.ProgSel;
              bus.StartAddr  <= sel_addr;
              bus.CycleCount <= '0;
              bus.TimedOut   <= 1'b0;
              bus.Init       <= 1'b1;
              bus.LoadPC     <= 1'b1;
              bus.Busy       <= 1'b1;
            end else begin
              bus.BadSel <= 1'b1;
            end
          end
        end
        INIT: begin
          init_cnt <= init_cnt - 4'd1;
          if (init_cnt <= 4'd1) begin
            state      <= RUN;
            bus.Init   <= 1'b0;
            bus.LoadPC <= 1'b0;
          end
        end
        RUN: begin
          bus.CycleCount <= count_inc;
          // A zero count marks the first RUN cycle, where Halt is still stale.
          if (bus.Halt && bus.CycleCount != 16'd0) begin
            state    <= DONE;
            bus.Init <= 1'b1;
            bus.Busy <= 1'b0;
            bus.Done <= 1'b1;
          end else if (count_inc == TIMEOUT) begin
            state        <= DONE;
            bus.Init     <= 1'b1;
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b1;
            bus.TimedOut <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.Start) begin
            state    <= IDLE;
            bus.Done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the instruction-fetch stage. It accepts a start request and a program select from the host or testbench, then holds the fetch unit in init while presenting that program's start address. It releases the processor to run, watches the fetch unit's Halt flag with a watchdog, and reports Done, a timeout flag and the run's cycle count. It sits between the top-level harness and the fetch stage, driving that stage's Init, ProgState and start-PC load.

## Interface
Parameters:
- NUM_PROGS, 3: number of valid programs; ProgSel values >= NUM_PROGS are rejected.
- START0, 10'd0: start PC of program 0.
- START1, 10'd128: start PC of program 1.
- START2, 10'd256: start PC of program 2.
- INIT_CYCLES, 2: cycles Init is held before run (legal range 1..15).
- TIMEOUT, 16'd4000: RUN cycles allowed before the watchdog fires (legal range >= 2).

Ports:
- CLK, in, 1: sole clock; all state changes on posedge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: level request to run the selected program.
- ProgSel, in, 2: program index; sampled only on the accepting edge.
- Halt, in, 1: done flag from the fetch stage.
- Init, out, 1: holds the fetch stage (PC frozen) while high.
- LoadPC, out, 1: PC-load strobe to the fetch stage.
- StartAddr, out, 10: PC value to load while LoadPC is high.
- ProgState, out, 2: latched program index, forwarded to the fetch stage and datapath.
- Busy, out, 1: high in INIT and RUN.
- Done, out, 1: run finished (normal or timeout).
- TimedOut, out, 1: last run ended by the watchdog.
- BadSel, out, 1: one-cycle pulse when a Start is rejected.
- CycleCount, out, 16: RUN cycles of the current or last run.

## Operation
- States: IDLE, INIT, RUN, DONE.
- Reset (async) forces the following, effective immediately and regardless of the state it interrupts:
  - state = IDLE, Init = 1, LoadPC = 0, StartAddr = 0, ProgState = 0.
  - Busy = 0, Done = 0, TimedOut = 0, BadSel = 0, CycleCount = 0.
- IDLE: Init = 1.
  - Start = 1 with ProgSel < NUM_PROGS: latch ProgState = ProgSel, load StartAddr from START0/1/2, clear CycleCount, clear TimedOut, load init counter with INIT_CYCLES, go to INIT.
  - Start = 1 with ProgSel >= NUM_PROGS: BadSel = 1 for one cycle, stay in IDLE.
- INIT: Init = 1, LoadPC = 1, StartAddr stable.
  - The init counter decrements each cycle; at 1 go to RUN.
- RUN: Init = 0, LoadPC = 0.
  - CycleCount increments every RUN cycle, saturating at 16'hFFFF.
  - Halt is ignored in the first RUN cycle, because the fetch stage's Halt is stale from the previous run until it clocks once.
  - From the second RUN cycle, Halt = 1 goes to DONE.
  - If CycleCount reaches TIMEOUT without a qualifying Halt, set TimedOut = 1 and go to DONE.
  - Halt and the timeout on the same edge: Halt wins, TimedOut = 0.
- DONE: Init = 1 (PC frozen), Done = 1; CycleCount, TimedOut and ProgState are held.
  - Start = 0 returns to IDLE; Done stays high until that transition.
  - Start still high stays in DONE (four-phase handshake, no auto-restart).
- ProgSel changes after acceptance have no effect until the next IDLE acceptance.

## Timing
- All outputs are registered, Moore style.
- Start accepted at edge k: Init high and LoadPC high from k through k+INIT_CYCLES.
  - Init first low in cycle k+INIT_CYCLES+1.
- Halt sampled high at RUN edge j (j >= second RUN cycle): Done is high the cycle after edge j.
  - CycleCount then equals the number of RUN cycles including cycle j.
- Timeout: Done and TimedOut rise together, and CycleCount = TIMEOUT.
- Start falling in DONE: Done low and state IDLE after the next edge.
  - Minimum restart gap is 2 cycles (Start low, then high).
- Reset asserted mid-RUN: Init goes high asynchronously and the fetch PC freezes.
  - No Done is produced; the next Start begins a fresh run.

## Test plan
- Reset, then ProgSel = 1, Start = 1 at edge 0 with defaults:
  - Init and LoadPC high for 2 cycles with StartAddr = 128 and ProgState = 1.
  - Init low at cycle 3, Busy = 1.
- Halt raised after 50 RUN cycles: Done = 1 next cycle, CycleCount = 50, TimedOut = 0.
  - Drop Start: IDLE next cycle, Done = 0, count held at 50.
- Halt held at 1 (stale) when RUN begins: the first RUN cycle is ignored, DONE entered one cycle later with CycleCount = 2.
- Halt never asserted, TIMEOUT = 16'd20: Done = 1 and TimedOut = 1 with CycleCount = 20.
  - Repeat with Halt and the timeout on the same edge: TimedOut = 0.
- ProgSel = 3, Start = 1: BadSel pulses one cycle, Init stays 1, Busy stays 0.
  - ProgSel = 0 then accepted normally with StartAddr = 0.
- Reset pulsed mid-RUN (between edges): Init = 1 and Busy = 0 immediately, with every output at its reset value.
  - A subsequent Start runs normally.
